// File: rtl/sqrt_pkg.sv
// sqrt_pkg: width helpers and state encoding shared by the digit-serial square root.
package sqrt_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int root_w(input int int_w, input int frac_out);
    return int_w / 2 + frac_out;
  endfunction
  function automatic int rem_w(input int n);
    return n + 2;
  endfunction
  function automatic int iter_cycles(input int n, input int res);
    return (n + res - 1) / res;
  endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one restoring square-root iteration consuming a single radicand pair.
module sqrt_step #(
  parameter int REM_W = 17,
  parameter int N = 15
) (
  input  logic [REM_W-1:0] r,
  input  logic [N-1:0]     q,
  input  logic [1:0]       pair,
  output logic [REM_W-1:0] r_next,
  output logic [N-1:0]     q_next
);
  logic [REM_W-1:0] rs, t;
  logic ge;
  assign rs = (r << 2) | REM_W'(pair);
  assign t = {q, 2'b01};
  assign ge = rs >= t;
  assign r_next = ge ? rs - t : rs;
  assign q_next = (q << 1) | N'(ge);
endmodule

// File: rtl/sqrt_digit_serial.sv
// sqrt_digit_serial: multi-cycle unsigned fixed-point square root, 1 or 2 root bits per clock.
module sqrt_digit_serial
  import sqrt_pkg::*;
#(
  parameter int INT_W = 16,
  parameter int FRAC_IN = 6,
  parameter int FRAC_OUT = 7,
  parameter int RES_PER_CYC = 1,
  localparam int N = root_w(INT_W, FRAC_OUT),
  localparam int REM_W = rem_w(N),
  localparam int C = iter_cycles(N, RES_PER_CYC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [INT_W+FRAC_IN-1:0] num,
  output logic                     busy,
  output logic                     done,
  output logic [N-1:0]             root,
  output logic [REM_W-1:0]         rem,
  output logic                     exact
);
  // A leading zero pair (odd N, two per clock) leaves r and q at zero, so the
  // first clock effectively performs a single real iteration.
  localparam int SW = 2 * C * RES_PER_CYC;
  localparam int CW = $clog2(C + 1);
  localparam int SH = 2 * FRAC_OUT - FRAC_IN;
  if (INT_W < 2 || INT_W % 2 != 0 || FRAC_IN % 2 != 0 || SH < 0 ||
      (RES_PER_CYC != 1 && RES_PER_CYC != 2)) begin : g_bad_params
    $error("sqrt_digit_serial: illegal parameter combination");
  end
  state_t state;
  logic [SW-1:0] sr;
  logic [REM_W-1:0] r;
  logic [N-1:0] q;
  logic [CW-1:0] cnt;
  logic [REM_W-1:0] r_c [RES_PER_CYC+1];
  logic [N-1:0] q_c [RES_PER_CYC+1];
  assign r_c[0] = r;
  assign q_c[0] = q;
  for (genvar i = 0; i < RES_PER_CYC; i++) begin : g_step
    sqrt_step #(.REM_W(REM_W), .N(N)) u_step (
      .r(r_c[i]), .q(q_c[i]), .pair(sr[SW-1-2*i -: 2]),
      .r_next(r_c[i+1]), .q_next(q_c[i+1])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      root <= '0;
      rem <= '0;
      exact <= 1'b0;
      cnt <= '0;
      sr <= '0;
      r <= '0;
      q <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sr <= SW'(num) << SH;
          r <= '0;
          q <= '0;
          cnt <= CW'(C);
          busy <= 1'b1;
          state <= RUN;
        end
      end else begin
        sr <= sr << (2 * RES_PER_CYC);
        r <= r_c[RES_PER_CYC];
        q <= q_c[RES_PER_CYC];
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          root <= q_c[RES_PER_CYC];
          rem <= r_c[RES_PER_CYC];
          exact <= r_c[RES_PER_CYC] == '0;
        end
      end
    end
endmodule

// File: tb/tb_sqrt_digit_serial.sv
// tb_sqrt_digit_serial: directed and random checks of narrow and wide instances against an integer-sqrt model.
module tb_sqrt_digit_serial;
  logic clk = 0, reset = 1, start1 = 0, start2 = 0;
  logic [21:0] num = '0;
  logic busy1, done1, exact1, busy2, done2, exact2;
  logic [14:0] root1, root2;
  logic [16:0] rem1, rem2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sqrt_digit_serial u1 (.clk(clk), .reset(reset), .start(start1), .num(num), .busy(busy1),
    .done(done1), .root(root1), .rem(rem1), .exact(exact1));
  sqrt_digit_serial #(.RES_PER_CYC(2)) u2 (.clk(clk), .reset(reset), .start(start2), .num(num),
    .busy(busy2), .done(done2), .root(root2), .rem(rem2), .exact(exact2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Root is floor(sqrt(num * 2^8)), built bit by bit from squares.
  function automatic void model(input logic [21:0] v, output logic [14:0] rt, output logic [16:0] rm);
    longint x, s;
    x = longint'(v) << 8;
    s = 0;
    for (int b = 14; b >= 0; b--)
      if ((s + (64'd1 << b)) * (s + (64'd1 << b)) <= x) s = s + (64'd1 << b);
    rt = 15'(s);
    rm = 17'(x - s * s);
  endfunction

  function automatic logic out_done(input bit w);
    return w ? done2 : done1;
  endfunction

  task automatic op(input string tag, input bit w, input logic [21:0] v, input bit poke);
    logic [14:0] er;
    logic [16:0] erem;
    int n;
    model(v, er, erem);
    @(negedge clk);
    num = v;
    if (w) start2 = 1; else start1 = 1;
    @(negedge clk);
    start1 = 0;
    start2 = 0;
    num = ~v;
    check({tag, ".busy"}, w ? busy2 : busy1, 1);
    n = 0;
    while (!out_done(w) && n < 40) begin
      @(negedge clk);
      n++;
      if (poke) begin
        if (w) start2 = (n == 5); else start1 = (n == 5);
      end
    end
    start1 = 0;
    start2 = 0;
    check({tag, ".lat"}, n, w ? 8 : 15);
    check({tag, ".root"}, w ? root2 : root1, er);
    check({tag, ".rem"}, w ? rem2 : rem1, erem);
    check({tag, ".exact"}, w ? exact2 : exact1, erem == 0);
    check({tag, ".busy_end"}, w ? busy2 : busy1, 0);
    @(negedge clk);
    check({tag, ".pulse"}, out_done(w), 0);
    if (poke) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        n += int'(out_done(w)) + int'(w ? busy2 : busy1);
      end
      check({tag, ".quiet"}, n, 0);
    end
  endtask

  initial begin
    int dc[$];
    int cnt;
    #12;
    check("rst.busy", busy1, 0);
    check("rst.done", done1, 0);
    check("rst.root", root1, 0);
    check("rst.rem", rem1, 0);
    check("rst.exact", exact1, 0);
    check("rst.busy2", busy2, 0);
    reset = 0;
    op("sq144", 0, 22'd9216, 0);
    check("sq144.root_lit", root1, 1536);
    op("two", 0, 22'd128, 0);
    check("two.root_lit", root1, 181);
    op("max", 0, 22'h3FFFFF, 0);
    check("max.rem_lit", rem1, 65279);
    op("zero", 0, 22'd0, 0);
    op("poke", 0, 22'd50000, 1);
    op("w.two", 1, 22'd128, 0);
    check("w.two.root_lit", root2, 181);
    op("w.max", 1, 22'h3FFFFF, 0);
    for (int k = 0; k < 6; k++) op("rnd", 0, 22'($urandom), 0);
    for (int k = 0; k < 6; k++) op("w.rnd", 1, 22'($urandom), 0);
    // Held start: accepts back-to-back every C+1 cycles.
    @(negedge clk);
    num = 22'd9216;
    start1 = 1;
    @(negedge clk);
    for (int n = 0; n < 50; n++) begin
      if (done1) dc.push_back(n);
      @(negedge clk);
    end
    start1 = 0;
    check("hold.count", dc.size(), 3);
    if (dc.size() == 3) begin
      check("hold.first", dc[0], 15);
      check("hold.gap1", dc[1] - dc[0], 16);
      check("hold.gap2", dc[2] - dc[1], 16);
    end
    check("hold.root", root1, 1536);
    cnt = 0;
    while (busy1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("hold.idle", busy1, 0);
    // Reset mid-run.
    @(negedge clk);
    num = 22'd128;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    repeat (5) @(negedge clk);
    reset = 1;
    #1;
    check("mid.busy", busy1, 0);
    check("mid.done", done1, 0);
    check("mid.root", root1, 0);
    check("mid.rem", rem1, 0);
    check("mid.exact", exact1, 0);
    @(negedge clk);
    reset = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(done1);
    end
    check("mid.nodone", cnt, 0);
    op("after_rst", 0, 22'd128, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqrt_digit_serial.md
# sqrt_digit_serial

Parametrised digit-by-digit (restoring) unsigned fixed-point square root with a start/done handshake. It produces the root, the final remainder and an exactness flag, retiring 1 or 2 root bits per clock. It is the general-purpose successor to the team's fixed-format 16.6 → 8.7 square-root unit and is intended for use wherever a multi-cycle, low-area root is acceptable.

## Interface
Parameters:
- INT_W, default 16: radicand integer bits; must be even and ≥ 2.
- FRAC_IN, default 6: radicand fraction bits; must be even.
- FRAC_OUT, default 7: root fraction bits; must satisfy 2·FRAC_OUT ≥ FRAC_IN.
- RES_PER_CYC, default 1: root bits resolved per clock; legal values are 1 and 2.

Derived values:
- N = INT_W/2 + FRAC_OUT (root width).
- C = ceil(N/RES_PER_CYC) (iteration cycles).
- REM_W = N+2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only while busy=0.
- num  in  INT_W+FRAC_IN  unsigned radicand, binary point FRAC_IN from the LSB.
- busy  out  1  high from the accept edge until the last iteration edge.
- done  out  1  one-cycle pulse; root, rem and exact are valid while it is high.
- root  out  N  unsigned root, binary point FRAC_OUT from the LSB.
- rem  out  REM_W  final remainder, X − root².
- exact  out  1  high when rem==0.

## Operation
- Working radicand: X = num << (2·FRAC_OUT − FRAC_IN), giving 2N bits processed as N two-bit pairs, MSB pair first.
- Accept (start=1 and busy=0 at an edge):
  - load X into the pair shift register;
  - clear the working remainder and root;
  - set cnt=C and busy=1;
  - num is not required to remain stable after the accept edge.
- Each RUN edge performs RES_PER_CYC iterations. One iteration is:
  - r' = (r<<2) | pair;
  - t = (q<<2) | 1;
  - if r' ≥ t then r = r' − t and q = (q<<1) | 1, else r = r' and q = q<<1.
- When N is odd and RES_PER_CYC=2, the first RUN edge performs exactly one iteration; all later RUN edges perform two.
- Final edge (cnt 1→0):
  - root, rem and exact register the final values;
  - done=1 and busy=0.
- Hold behaviour:
  - root, rem and exact hold until the next final edge;
  - done drops after one cycle.
- start while busy=1 is ignored; it is neither queued nor an error.
- Widths:
  - the working remainder is REM_W bits and never overflows, since r ≤ 2q;
  - the compare is unsigned at REM_W bits.

## Timing
- Reset values: busy=0, done=0, root=0, rem=0, exact=0, cnt=0.
- Latency: start is accepted at edge k, and done is high for the cycle after edge k+C.
  - Defaults: C=15 when RES_PER_CYC=1 and C=8 when RES_PER_CYC=2.
- Throughput: a start held high is re-accepted at edge k+C+1, because busy is already low. done and the new accept coincide at that edge, and done still pulses for exactly one cycle.
- Reset asserted mid-operation:
  - all state clears immediately, with no done pulse;
  - after release, the first accepted start behaves as from idle.
- Outputs are driven only by registers; no combinational path runs from start or num to any output.

## Structure
- Package sqrt_pkg holds:
  - the width functions root_w(), rem_w() and iter_cycles();
  - the state encoding IDLE/RUN.
- Sub-module sqrt_step: one combinational iteration with inputs (r, q, pair) and outputs (r', q'), parametrised by REM_W and N. It is instantiated RES_PER_CYC times in a chain.
- The top level contains the counter, the pair shift register, the two-state FSM and the output registers. Parameter legality is enforced by an elaboration-time check.

## Test plan
All scenarios use default parameters unless stated.
1. Exact square: num=144.0 (code 9216) → after 15 cycles root=1536 (12.0), rem=0, exact=1, done high for one cycle.
2. Irrational root: num=2.0 (code 128) → root=181, rem=7, exact=0.
3. Maximum input: num=22'h3FFFFF → root=15'h7FFF, rem=65279.
4. Zero input: num=0 → root=0, rem=0, exact=1, done still pulses after 15 cycles.
5. Handshake:
   - start pulsed again during busy → ignored, and a single result is returned;
   - start held high continuously → accepts every 16 cycles.
6. Reset mid-computation and wide mode:
   - reset asserted at cycle 5 of a run → all outputs are 0 immediately and no done appears;
   - with RES_PER_CYC=2, scenario 2 gives the same result with done after 8 cycles.
